// File: rtl/rst_pulse_gen_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and reset-cause codes.
package rst_pulse_gen_pkg;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    RUN      = 2'd1,
    ACK_WAIT = 2'd2
  } rst_state_e;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'b00,
    CAUSE_EXT = 2'b01,
    CAUSE_SW  = 2'b10
  } rst_cause_e;

endpackage

// File: rtl/rst_pulse_gen_if.sv
// Request/acknowledge and reset-output bundle of rst_pulse_gen.
// evt_cnt (and EVT_CNT_W) exist only when RST_PULSE_GEN_EVT_CNT_EN is defined.
interface rst_pulse_gen_if
`ifdef RST_PULSE_GEN_EVT_CNT_EN
  #(parameter int unsigned EVT_CNT_W = 8)
`endif
  ;
  import rst_pulse_gen_pkg::*;

  logic       ext_rst_req;
  logic       sw_rst_req;
  logic       sw_rst_ack;
  logic       rst_n_out;
  rst_cause_e rst_cause;
`ifdef RST_PULSE_GEN_EVT_CNT_EN
  logic [EVT_CNT_W-1:0] evt_cnt;

  modport master (output ext_rst_req, sw_rst_req,
                  input  sw_rst_ack, rst_n_out, rst_cause, evt_cnt);
  modport slave  (input  ext_rst_req, sw_rst_req,
                  output sw_rst_ack, rst_n_out, rst_cause, evt_cnt);
`else
  modport master (output ext_rst_req, sw_rst_req,
                  input  sw_rst_ack, rst_n_out, rst_cause);
  modport slave  (input  ext_rst_req, sw_rst_req,
                  output sw_rst_ack, rst_n_out, rst_cause);
`endif

endinterface

// File: rtl/rst_pulse_gen_sync.sv
// SYNC_STAGES-deep single-bit synchronizer with async active-high clear to 0.
module rst_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_pulse_gen.sv
// Reset sequencer: merges POR, async external and handshaked software requests
// into a minimum-width active-low reset. Optional event counter: RST_PULSE_GEN_EVT_CNT_EN.
module rst_pulse_gen
  import rst_pulse_gen_pkg::*;
#(
  parameter int unsigned MIN_LOW_CYCLES = 6,
  parameter int unsigned SYNC_STAGES    = 2
`ifdef RST_PULSE_GEN_EVT_CNT_EN
  , parameter int unsigned EVT_CNT_W    = 8
`endif
) (
  input logic             clk,
  input logic             rst,
  rst_pulse_gen_if.slave  bus
);

  localparam int unsigned     CNT_W   = $clog2(MIN_LOW_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_LOW_CYCLES);

  rst_state_e       state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             rst_n_q, rst_n_d;
  logic             ack_q, ack_d;
  rst_cause_e       cause_q, cause_d;
  logic             enter_hold;
  logic             ext_sync;

  rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ext_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.ext_rst_req),
    .q_o (ext_sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
      rst_n_q    <= 1'b0;
      ack_q      <= 1'b0;
      cause_q    <= CAUSE_POR;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rst_n_q    <= rst_n_d;
      ack_q      <= ack_d;
      cause_q    <= cause_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rst_n_d    = rst_n_q;
    ack_d      = ack_q;
    cause_d    = cause_q;
    enter_hold = 1'b0;

    unique case (state_q)
      HOLD: begin
        // An active external request pins the count at zero, even when the window has just completed.
        if (ext_sync) begin
          hold_cnt_d = '0;
          cause_d    = CAUSE_EXT;
        end else if (hold_cnt_q == CNT_MAX) begin
          rst_n_d = 1'b1;
          if (bus.sw_rst_req) begin
            state_d = ACK_WAIT;
            ack_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (ext_sync) begin
          enter_hold = 1'b1;
          cause_d    = CAUSE_EXT;
        end else if (bus.sw_rst_req) begin
          enter_hold = 1'b1;
          cause_d    = CAUSE_SW;
        end
      end
      ACK_WAIT: begin
        if (ext_sync) begin
          enter_hold = 1'b1;
          cause_d    = CAUSE_EXT;
        end else if (!bus.sw_rst_req) begin
          state_d = RUN;
          ack_d   = 1'b0;
        end
      end
      default: state_d = HOLD;
    endcase

    if (enter_hold) begin
      state_d    = HOLD;
      rst_n_d    = 1'b0;
      hold_cnt_d = '0;
      ack_d      = 1'b0;
    end
  end

  assign bus.rst_n_out  = rst_n_q;
  assign bus.sw_rst_ack = ack_q;
  assign bus.rst_cause  = cause_q;

`ifdef RST_PULSE_GEN_EVT_CNT_EN
  logic [EVT_CNT_W-1:0] evt_q, evt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  always_comb begin
    evt_d = evt_q;
    if (enter_hold && (evt_q != '1)) begin
      evt_d = evt_q + 1'b1;
    end
  end

  assign bus.evt_cnt = evt_q;
`endif

endmodule

// File: tb/tb_rst_pulse_gen.sv
// Directed self-checking bench for rst_pulse_gen (MIN_LOW_CYCLES=6, SYNC_STAGES=2).
module tb_rst_pulse_gen;

  localparam int unsigned MIN = 6;

  logic clk;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

`ifdef RST_PULSE_GEN_EVT_CNT_EN
  rst_pulse_gen_if #(.EVT_CNT_W(8)) bus ();
`else
  rst_pulse_gen_if bus ();
`endif

  rst_pulse_gen #(
    .MIN_LOW_CYCLES (6),
    .SYNC_STAGES    (2)
`ifdef RST_PULSE_GEN_EVT_CNT_EN
    , .EVT_CNT_W    (8)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimum-width monitor: after a sampled falling edge, the next MIN samples must be low.
  logic mon_prev = 1'b0;
  int   mon_need = 0;
  always @(negedge clk) begin
    if (mon_need > 0) begin
      n_assert++;
      if (bus.rst_n_out !== 1'b0) begin
        n_fail++;
        $display("FAIL min_low_window: rst_n_out=%b required 0 (%0d samples left) at %0t",
                 bus.rst_n_out, mon_need, $time);
      end
      mon_need--;
    end else if (mon_prev === 1'b1 && bus.rst_n_out === 1'b0) begin
      mon_need = MIN;
    end
    mon_prev = bus.rst_n_out;
  end

  task automatic test_reset();
    logic exp_n;
    rst = 1'b1;
    bus.ext_rst_req = 1'b0;
    bus.sw_rst_req  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_assert++;
    if (bus.rst_n_out !== 1'b0) begin n_fail++; $display("FAIL por_rst_n: got %b want 0", bus.rst_n_out); end
    n_assert++;
    if (bus.sw_rst_ack !== 1'b0) begin n_fail++; $display("FAIL por_ack: got %b want 0", bus.sw_rst_ack); end
    n_assert++;
    if (bus.rst_cause !== 2'b00) begin n_fail++; $display("FAIL por_cause: got %b want 00", bus.rst_cause); end
`ifdef RST_PULSE_GEN_EVT_CNT_EN
    n_assert++;
    if (bus.evt_cnt !== 8'd0) begin n_fail++; $display("FAIL por_evt: got %0d want 0", bus.evt_cnt); end
`endif
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      exp_n = (i == 7);
      n_assert++;
      if (bus.rst_n_out !== exp_n) begin
        n_fail++; $display("FAIL por_release edge %0d: got %b want %b", i, bus.rst_n_out, exp_n);
      end
    end
    n_assert++;
    if (bus.rst_cause !== 2'b00) begin n_fail++; $display("FAIL por_cause_after: got %b want 00", bus.rst_cause); end
    n_assert++;
    if (bus.sw_rst_ack !== 1'b0) begin n_fail++; $display("FAIL por_ack_after: got %b want 0", bus.sw_rst_ack); end
  endtask

  task automatic test_sw();
    logic exp_v;
    bus.sw_rst_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      exp_v = (i == 8);
      n_assert++;
      if (bus.rst_n_out !== exp_v) begin
        n_fail++; $display("FAIL sw_rst_n edge %0d: got %b want %b", i, bus.rst_n_out, exp_v);
      end
      n_assert++;
      if (bus.sw_rst_ack !== exp_v) begin
        n_fail++; $display("FAIL sw_ack edge %0d: got %b want %b", i, bus.sw_rst_ack, exp_v);
      end
      if (i == 1) begin
        n_assert++;
        if (bus.rst_cause !== 2'b10) begin n_fail++; $display("FAIL sw_cause: got %b want 10", bus.rst_cause); end
      end
    end
    bus.sw_rst_req = 1'b0;
    @(negedge clk);
    n_assert++;
    if (bus.sw_rst_ack !== 1'b0) begin n_fail++; $display("FAIL sw_ack_drop: got %b want 0", bus.sw_rst_ack); end
    n_assert++;
    if (bus.rst_n_out !== 1'b1) begin n_fail++; $display("FAIL sw_run_rst_n: got %b want 1", bus.rst_n_out); end
    n_assert++;
    if (bus.rst_cause !== 2'b10) begin n_fail++; $display("FAIL sw_cause_after: got %b want 10", bus.rst_cause); end
  endtask

  task automatic test_ext();
    logic exp_n;
    bus.ext_rst_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      exp_n = (i < 3);
      n_assert++;
      if (bus.rst_n_out !== exp_n) begin
        n_fail++; $display("FAIL ext_hold edge %0d: got %b want %b", i, bus.rst_n_out, exp_n);
      end
      if (i == 3) begin
        n_assert++;
        if (bus.rst_cause !== 2'b01) begin n_fail++; $display("FAIL ext_cause: got %b want 01", bus.rst_cause); end
      end
    end
    bus.ext_rst_req = 1'b0;
    for (int i = 21; i <= 29; i++) begin
      @(negedge clk);
      exp_n = (i == 29);
      n_assert++;
      if (bus.rst_n_out !== exp_n) begin
        n_fail++; $display("FAIL ext_release edge %0d: got %b want %b", i, bus.rst_n_out, exp_n);
      end
    end
    n_assert++;
    if (bus.rst_cause !== 2'b01) begin n_fail++; $display("FAIL ext_cause_after: got %b want 01", bus.rst_cause); end
    n_assert++;
    if (bus.sw_rst_ack !== 1'b0) begin n_fail++; $display("FAIL ext_ack: got %b want 0", bus.sw_rst_ack); end
  endtask

  task automatic test_ext_restart();
    logic exp_v;
    bus.sw_rst_req = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      exp_v = (i == 17);
      n_assert++;
      if (bus.rst_n_out !== exp_v) begin
        n_fail++; $display("FAIL restart_rst_n edge %0d: got %b want %b", i, bus.rst_n_out, exp_v);
      end
      n_assert++;
      if (bus.sw_rst_ack !== exp_v) begin
        n_fail++; $display("FAIL restart_ack edge %0d: got %b want %b", i, bus.sw_rst_ack, exp_v);
      end
      if (i == 7) begin
        n_assert++;
        if (bus.rst_cause !== 2'b10) begin n_fail++; $display("FAIL restart_cause_pre: got %b want 10", bus.rst_cause); end
      end
      if (i == 8) begin
        n_assert++;
        if (bus.rst_cause !== 2'b01) begin n_fail++; $display("FAIL restart_cause: got %b want 01", bus.rst_cause); end
      end
      if (i == 5) bus.ext_rst_req = 1'b1;
      if (i == 8) bus.ext_rst_req = 1'b0;
    end
  endtask

  task automatic test_rst_in_ack();
    logic exp_n;
    #2;
    rst = 1'b1;
    #1;
    n_assert++;
    if (bus.sw_rst_ack !== 1'b0) begin n_fail++; $display("FAIL async_ack: got %b want 0", bus.sw_rst_ack); end
    n_assert++;
    if (bus.rst_n_out !== 1'b0) begin n_fail++; $display("FAIL async_rst_n: got %b want 0", bus.rst_n_out); end
    n_assert++;
    if (bus.rst_cause !== 2'b00) begin n_fail++; $display("FAIL async_cause: got %b want 00", bus.rst_cause); end
    bus.sw_rst_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      exp_n = (i == 7);
      n_assert++;
      if (bus.rst_n_out !== exp_n) begin
        n_fail++; $display("FAIL async_release edge %0d: got %b want %b", i, bus.rst_n_out, exp_n);
      end
    end
    n_assert++;
    if (bus.rst_cause !== 2'b00) begin n_fail++; $display("FAIL async_cause_after: got %b want 00", bus.rst_cause); end
  endtask

  task automatic test_priority();
    logic exp_n;
    bus.ext_rst_req = 1'b1;
    repeat (2) @(negedge clk);
    n_assert++;
    if (bus.rst_n_out !== 1'b1) begin n_fail++; $display("FAIL prio_pre: got %b want 1", bus.rst_n_out); end
    bus.sw_rst_req = 1'b1;
    @(negedge clk);
    n_assert++;
    if (bus.rst_n_out !== 1'b0) begin n_fail++; $display("FAIL prio_rst_n: got %b want 0", bus.rst_n_out); end
    n_assert++;
    if (bus.rst_cause !== 2'b01) begin n_fail++; $display("FAIL prio_cause: got %b want 01", bus.rst_cause); end
    bus.ext_rst_req = 1'b0;
    bus.sw_rst_req  = 1'b0;
    for (int i = 4; i <= 12; i++) begin
      @(negedge clk);
      exp_n = (i == 12);
      n_assert++;
      if (bus.rst_n_out !== exp_n) begin
        n_fail++; $display("FAIL prio_release edge %0d: got %b want %b", i, bus.rst_n_out, exp_n);
      end
    end
    n_assert++;
    if (bus.sw_rst_ack !== 1'b0) begin n_fail++; $display("FAIL prio_ack: got %b want 0", bus.sw_rst_ack); end
  endtask

`ifdef RST_PULSE_GEN_EVT_CNT_EN
  task automatic do_sw_event();
    bit seen = 1'b0;
    bus.sw_rst_req = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.sw_rst_ack === 1'b1) seen = 1'b1;
    end
    n_assert++;
    if (!seen) begin n_fail++; $display("FAIL evt_sw_timeout: ack=%b required 1", bus.sw_rst_ack); end
    bus.sw_rst_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_ext_event();
    bit seen = 1'b0;
    bus.ext_rst_req = 1'b1;
    repeat (3) @(negedge clk);
    bus.ext_rst_req = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (bus.rst_n_out === 1'b1) seen = 1'b1;
    end
    n_assert++;
    if (!seen) begin n_fail++; $display("FAIL evt_ext_timeout: rst_n_out=%b required 1", bus.rst_n_out); end
  endtask

  task automatic test_evt_cnt();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (7) @(negedge clk);
    n_assert++;
    if (bus.evt_cnt !== 8'd0) begin n_fail++; $display("FAIL evt_por: got %0d want 0", bus.evt_cnt); end
    repeat (3) do_sw_event();
    repeat (2) do_ext_event();
    n_assert++;
    if (bus.evt_cnt !== 8'd5) begin n_fail++; $display("FAIL evt_five: got %0d want 5", bus.evt_cnt); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (7) @(negedge clk);
    n_assert++;
    if (bus.evt_cnt !== 8'd0) begin n_fail++; $display("FAIL evt_por_clear: got %0d want 0", bus.evt_cnt); end
    repeat (254) do_sw_event();
    n_assert++;
    if (bus.evt_cnt !== 8'd254) begin n_fail++; $display("FAIL evt_254: got %0d want 254", bus.evt_cnt); end
    do_sw_event();
    n_assert++;
    if (bus.evt_cnt !== 8'd255) begin n_fail++; $display("FAIL evt_255: got %0d want 255", bus.evt_cnt); end
    repeat (45) do_sw_event();
    n_assert++;
    if (bus.evt_cnt !== 8'd255) begin n_fail++; $display("FAIL evt_sat: got %0d want 255", bus.evt_cnt); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sw();
    test_ext();
    test_ext_restart();
    test_rst_in_ack();
    test_priority();
`ifdef RST_PULSE_GEN_EVT_CNT_EN
    test_evt_cnt();
`endif
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
